speaker_i2s_tx: RTL and testbench

//  Consumer end of the 16-bit stereo audio sample interface; sits between the

---
 rtl/speaker_i2s_tx.sv | 92 +++++++++
 tb/tb_speaker_i2s_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/speaker_i2s_tx.sv
// I2S transmitter for the on-board audio DAC: a free-running divider makes MCLK/SCK/LRCK,
// and a frame-coherent L/R pair is serialized MSB first. Optional macro SPK_VOLUME_EN adds a shift-volume input.
module speaker_i2s_tx #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] audio_left,
  input  logic [SAMPLE_W-1:0] audio_right,
  input  logic                mute,
`ifdef SPK_VOLUME_EN
  input  logic [2:0]          volume,
`endif
  output logic                audio_mclk,
  output logic                audio_sck,
  output logic                audio_lrck,
  output logic                audio_sdin,
  output logic                sample_req
);

  logic [9:0]          cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] shadow_l_q, shadow_l_d;
  logic [SAMPLE_W-1:0] shadow_r_q, shadow_r_d;
  logic                mute_q, mute_d;
  logic                sdin_q, sdin_d;
  logic                req_q, req_d;

  logic                frame_start;
  logic                bit_edge;
  logic [4:0]          slot_nx;
  logic [5:0]          slot_ext;
  logic [5:0]          bit_idx;
  logic                slot_vld;
  logic [SAMPLE_W-1:0] word_nx;
  logic [SAMPLE_W-1:0] word_sh;

  assign cnt_d       = cnt_q + 10'd1;
  assign frame_start = (cnt_q == 10'h3FF);
  // sdin changes when the coming count enters a new slot, i.e. on the SCK falling edge
  assign bit_edge    = (cnt_d[3:0] == 4'd0);
  assign slot_nx     = cnt_d[8:4];
  assign slot_ext    = {1'b0, slot_nx};
  assign slot_vld    = (slot_nx != 5'd0) && (slot_ext <= 6'(SAMPLE_W));
  assign bit_idx     = 6'(SAMPLE_W) - slot_ext;
  assign word_nx     = cnt_d[9] ? shadow_r_q : shadow_l_q;
  assign word_sh     = word_nx >> bit_idx;

  always_comb begin
    shadow_l_d = shadow_l_q;
    shadow_r_d = shadow_r_q;
    mute_d     = mute_q;
    sdin_d     = sdin_q;
    req_d      = frame_start;
    if (frame_start) begin
`ifdef SPK_VOLUME_EN
      shadow_l_d = $signed(audio_left) >>> volume;
      shadow_r_d = $signed(audio_right) >>> volume;
`else
      shadow_l_d = audio_left;
      shadow_r_d = audio_right;
`endif
      mute_d = mute;
    end
    if (bit_edge)
      sdin_d = !mute_q && slot_vld && word_sh[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      shadow_l_q <= '0;
      shadow_r_q <= '0;
      mute_q     <= 1'b0;
      sdin_q     <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shadow_l_q <= shadow_l_d;
      shadow_r_q <= shadow_r_d;
      mute_q     <= mute_d;
      sdin_q     <= sdin_d;
      req_q      <= req_d;
    end
  end

  assign audio_mclk = cnt_q[1];
  assign audio_sck  = cnt_q[3];
  assign audio_lrck = cnt_q[9];
  assign audio_sdin = sdin_q;
  assign sample_req = req_q;

endmodule

// File: tb/tb_speaker_i2s_tx.sv
// Bench for speaker_i2s_tx: directed scenarios plus random frames, checked every cycle
// against a time-based reference model of the divider and frame data.
module tb_speaker_i2s_tx;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] audio_left = '0;
  logic [W-1:0] audio_right = '0;
  logic         mute = 1'b0;
`ifdef SPK_VOLUME_EN
  logic [2:0]   volume = '0;
`endif
  logic audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req;

  int cmp_n = 0;
  int err_n = 0;
  int t = 0;
  logic [W-1:0] ml = '0, mr = '0;
  logic         mm = 1'b0;
  logic [31:0]  cap_l = '0, cap_r = '0;

  speaker_i2s_tx #(.SAMPLE_W(W)) dut (
    .clk(clk), .rst(rst),
    .audio_left(audio_left), .audio_right(audio_right), .mute(mute),
`ifdef SPK_VOLUME_EN
    .volume(volume),
`endif
    .audio_mclk(audio_mclk), .audio_sck(audio_sck), .audio_lrck(audio_lrck),
    .audio_sdin(audio_sdin), .sample_req(sample_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // Serial bit for clock count c of the current frame under the I2S slot rules
  function automatic logic exp_sdin(input int c);
    int s;
    logic [W-1:0] w;
    s = (c / 16) % 32;
    w = (c >= 512) ? mr : ml;
    if (mm || s == 0 || s > W) return 1'b0;
    return w[W - s];
  endfunction

  task automatic check_all();
    int c;
    c = t % 1024;
    chk("mclk", 32'(audio_mclk), 32'((c / 2) % 2));
    chk("sck",  32'(audio_sck),  32'((c / 8) % 2));
    chk("lrck", 32'(audio_lrck), 32'(c / 512));
    chk("sreq", 32'(sample_req), 32'(c == 0 && t > 0));
    chk("sdin", 32'(audio_sdin), 32'(exp_sdin(c)));
    if (c % 16 == 8) begin
      if (c < 512) cap_l[31 - (c / 16) % 32] = audio_sdin;
      else         cap_r[31 - (c / 16) % 32] = audio_sdin;
    end
  endtask

  task automatic tick();
    if ((t + 1) % 1024 == 0) begin
`ifdef SPK_VOLUME_EN
      ml = $signed(audio_left) >>> volume;
      mr = $signed(audio_right) >>> volume;
`else
      ml = audio_left;
      mr = audio_right;
`endif
      mm = mute;
    end
    @(posedge clk);
    t++;
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until(input int target);
    while (t < target) tick();
  endtask

  task automatic release_rst();
    rst = 1'b0;
    t = 0; ml = '0; mr = '0; mm = 1'b0;
    check_all();
  endtask

  function automatic logic [31:0] word(input logic [W-1:0] v);
    return {1'b0, v, 15'b0};
  endfunction

  initial begin
    audio_left = 16'h8000; audio_right = 16'h7FFF;
    repeat (3) @(negedge clk);
    chk("rst_mclk", 32'(audio_mclk), 0);
    chk("rst_sck",  32'(audio_sck), 0);
    chk("rst_lrck", 32'(audio_lrck), 0);
    chk("rst_sdin", 32'(audio_sdin), 0);
    chk("rst_sreq", 32'(sample_req), 0);
    release_rst();

    run_until(1000);
    audio_left = 16'hA5C3; audio_right = 16'h0001;
    run_until(1023);
    chk("f0_left_zero", cap_l, 0);
    chk("f0_right_zero", cap_r, 0);
    run_until(2047);
    chk("f1_left", cap_l, word(16'hA5C3));
    chk("f1_right", cap_r, 32'h0000_8000);

    audio_left = 16'h1234;
    run_until(2048 + 300);
    audio_left = 16'hFFFF;
    run_until(3071);
    chk("late_change_keeps", cap_l, word(16'h1234));
    run_until(4095);
    chk("late_change_next", cap_l, word(16'hFFFF));

    run_until(4096 + 500);
    mute = 1'b1;
    run_until(5119);
    chk("mute_frame_intact", cap_l, word(16'hFFFF));
    run_until(6000);
    mute = 1'b0;
    run_until(6143);
    chk("muted_left", cap_l, 0);
    chk("muted_right", cap_r, 0);
    run_until(7167);
    chk("unmute_left", cap_l, word(16'hFFFF));
    chk("unmute_right", cap_r, 32'h0000_8000);

    // async reset during right-channel slot 8
    run_until(7168 + 643);
    rst = 1'b1;
    #1;
    chk("arst_mclk", 32'(audio_mclk), 0);
    chk("arst_sck",  32'(audio_sck), 0);
    chk("arst_lrck", 32'(audio_lrck), 0);
    chk("arst_sdin", 32'(audio_sdin), 0);
    chk("arst_sreq", 32'(sample_req), 0);
    repeat (3) @(negedge clk);
    release_rst();
    run_until(1023);
    chk("post_rst_left_zero", cap_l, 0);
    chk("post_rst_right_zero", cap_r, 0);

`ifdef SPK_VOLUME_EN
    volume = 3'd3; audio_left = 16'h8000; audio_right = 16'h4000;
    run_until(2047);
    chk("vol_left", cap_l, word(16'hF000));
    chk("vol_right", cap_r, word(16'h0800));
`endif

    for (int i = 0; i < 10; i++) begin
      run_until(t + 32'($urandom_range(50, 1100)));
      audio_left  = W'($urandom);
      audio_right = W'($urandom);
      mute        = ($urandom % 4) == 0;
`ifdef SPK_VOLUME_EN
      volume      = 3'($urandom);
`endif
    end
    run_until(t + 2100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
